// File: rtl/prio_cond_arbiter.sv
// Fixed-priority condition arbiter: captures a request vector, resolves the
// lowest set index (bit 0 wins) and offers it downstream on a valid/ready handshake.
module prio_cond_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output logic             gnt_valid_o,
  input  logic             gnt_ready_i,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic [N_REQ-1:0] gnt_onehot_o,
  output logic             multi_o,
  output logic             nomatch_o,
  output logic [CNT_W-1:0] nomatch_cnt_o,
  output logic             busy_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic             multi_q, multi_d;
  logic             nomatch_q, nomatch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ID_W-1:0]  win_id_s;
  logic [N_REQ-1:0] win_oh_s;
  logic             accept_s;

  // Lowest-index winner; descending scan lets bit 0 overwrite everything else.
  always_comb begin
    win_id_s = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_id_s = ID_W'(i);
      end else begin
        win_id_s = win_id_s;
      end
    end
    win_oh_s = req_i & (~req_i + N_REQ'(1));
  end

  // Next-state and captured-grant logic.
  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    gnt_oh_d  = gnt_oh_q;
    multi_d   = multi_q;
    nomatch_d = 1'b0;
    cnt_d     = cnt_q;
    accept_s  = req_valid_i && (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (|req_i) begin
            gnt_id_d = win_id_s;
            gnt_oh_d = win_oh_s;
            multi_d  = ($countones(req_i) > 1);
            state_d  = GRANT;
          end else begin
            nomatch_d = 1'b1;
            cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (gnt_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      gnt_oh_q  <= '0;
      multi_q   <= 1'b0;
      nomatch_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      gnt_oh_q  <= gnt_oh_d;
      multi_q   <= multi_d;
      nomatch_q <= nomatch_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign gnt_valid_o   = (state_q == GRANT);
  assign busy_o        = (state_q != IDLE);
  assign gnt_id_o      = gnt_id_q;
  assign gnt_onehot_o  = gnt_oh_q;
  assign multi_o       = multi_q;
  assign nomatch_o     = nomatch_q;
  assign nomatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_prio_cond_arbiter.sv
// Directed bench for prio_cond_arbiter with hand-computed expectations.
module tb_prio_cond_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       gnt_valid_o;
  logic       gnt_ready_i;
  logic [1:0] gnt_id_o;
  logic [3:0] gnt_onehot_o;
  logic       multi_o;
  logic       nomatch_o;
  logic [7:0] nomatch_cnt_o;
  logic       busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  prio_cond_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .gnt_valid_o(gnt_valid_o), .gnt_ready_i(gnt_ready_i),
    .gnt_id_o(gnt_id_o), .gnt_onehot_o(gnt_onehot_o), .multi_o(multi_o),
    .nomatch_o(nomatch_o), .nomatch_cnt_o(nomatch_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] id, input logic [3:0] oh, input logic mul);
    chk({tag, "_valid"},  32'(gnt_valid_o), 32'd1);
    chk({tag, "_ready"},  32'(req_ready_o), 32'd0);
    chk({tag, "_busy"},   32'(busy_o), 32'd1);
    chk({tag, "_id"},     32'(gnt_id_o), 32'(id));
    chk({tag, "_onehot"}, 32'(gnt_onehot_o), 32'(oh));
    chk({tag, "_multi"},  32'(multi_o), 32'(mul));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(gnt_valid_o), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_i = 4'b0000; req_valid_i = 1'b0; gnt_ready_i = 1'b0;
    tick(); tick();
    chk_idle("reset");
    chk("reset_id", 32'(gnt_id_o), 32'd0);
    chk("reset_oh", 32'(gnt_onehot_o), 32'd0);
    chk("reset_multi", 32'(multi_o), 32'd0);
    chk("reset_nomatch", 32'(nomatch_o), 32'd0);
    chk("reset_cnt", 32'(nomatch_cnt_o), 32'd0);

    // Overlapping request: bit 1 wins over bit 2
    rst_n = 1'b1; req_i = 4'b0110; req_valid_i = 1'b1;
    tick();
    chk_grant("g0110", 2'd1, 4'b0010, 1'b1);
    req_valid_i = 1'b0; gnt_ready_i = 1'b1;
    tick();
    chk_idle("rel0110");
    chk("rel0110_id_hold", 32'(gnt_id_o), 32'd1);
    chk("rel0110_multi_hold", 32'(multi_o), 32'd1);
    gnt_ready_i = 1'b0;

    // Back-pressure for 5 cycles
    req_i = 4'b1000; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0; req_i = 4'bxxxx;
    chk_grant("g1000", 2'd3, 4'b1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grant("stall", 2'd3, 4'b1000, 1'b0);
    end
    gnt_ready_i = 1'b1;
    tick();
    chk_idle("rel1000");
    gnt_ready_i = 1'b0;

    // Three isolated no-match samples
    for (int k = 1; k <= 3; k++) begin
      req_i = 4'b0000; req_valid_i = 1'b1;
      tick();
      chk("nm_pulse", 32'(nomatch_o), 32'd1);
      chk("nm_cnt", 32'(nomatch_cnt_o), 32'(k));
      chk("nm_valid", 32'(gnt_valid_o), 32'd0);
      chk("nm_id_hold", 32'(gnt_id_o), 32'd3);
      req_valid_i = 1'b0; req_i = 4'bxxxx;
      tick();
      chk("nm_drop", 32'(nomatch_o), 32'd0);
      chk("nm_x_valid", 32'(gnt_valid_o), 32'd0);
    end

    // Saturation: 260 back-to-back no-match samples starting from 3
    req_i = 4'b0000; req_valid_i = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      tick();
      chk("sat_cnt", 32'(nomatch_cnt_o), (3 + i > 255) ? 32'd255 : 32'(3 + i));
      chk("sat_pulse", 32'(nomatch_o), 32'd1);
    end
    req_valid_i = 1'b0;
    tick();
    chk("sat_hold", 32'(nomatch_cnt_o), 32'd255);
    chk("sat_drop", 32'(nomatch_o), 32'd0);

    // Requests during GRANT are ignored
    req_i = 4'b0100; req_valid_i = 1'b1;
    tick();
    chk_grant("g0100", 2'd2, 4'b0100, 1'b0);
    req_i = 4'b0001;
    tick();
    chk_grant("ign0001", 2'd2, 4'b0100, 1'b0);
    req_valid_i = 1'b0; gnt_ready_i = 1'b1;
    tick();
    chk_idle("rel0100");
    gnt_ready_i = 1'b0;
    tick();
    chk_idle("no_second");
    chk("no_second_id", 32'(gnt_id_o), 32'd2);

    // Build nomatch_cnt_o=7, grant pending, then reset mid-transaction
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req_i = 4'b0000; req_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    req_i = 4'b1010;
    tick();
    req_valid_i = 1'b0;
    chk("pre_rst_cnt", 32'(nomatch_cnt_o), 32'd7);
    chk_grant("g1010", 2'd1, 4'b0010, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_idle("midrst");
    chk("midrst_id", 32'(gnt_id_o), 32'd0);
    chk("midrst_oh", 32'(gnt_onehot_o), 32'd0);
    chk("midrst_multi", 32'(multi_o), 32'd0);
    chk("midrst_nomatch", 32'(nomatch_o), 32'd0);
    chk("midrst_cnt", 32'(nomatch_cnt_o), 32'd0);
    rst_n = 1'b1; req_i = 4'b0100; req_valid_i = 1'b1;
    tick();
    chk_grant("post_rst", 2'd2, 4'b0100, 1'b0);
    req_valid_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_cond_arbiter.md
Name: prio_cond_arbiter

Overview:
- Clocked fixed-priority condition arbiter. It samples a vector of condition/request bits, selects the lowest-index asserted bit (index 0 = highest priority, same evaluation order as a priority if/else-if chain), and presents the winner downstream on a valid/ready handshake.
- Sits directly upstream of the priority-decision consumer and feeds it one resolved branch index per transaction.
- Flags and counts "no branch matched" events, which are priority-if violations.

Parameters:
- N_REQ, 4, number of condition inputs (2..16)
- ID_W, $clog2(N_REQ), width of the encoded winner index
- CNT_W, 8, width of the saturating no-match counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_i  in  N_REQ  condition bits; bit 0 has highest priority
- req_valid_i  in  1  upstream strobe: req_i is valid this cycle
- req_ready_o  out  1  block can accept a sample
- gnt_valid_o  out  1  winner is presented downstream
- gnt_ready_i  in  1  downstream accepts the winner
- gnt_id_o  out  ID_W  encoded winner index
- gnt_onehot_o  out  N_REQ  one-hot winner
- multi_o  out  1  more than one req bit was set in the captured sample (overlap; not unique)
- nomatch_o  out  1  one-cycle pulse: accepted sample had no bit set
- nomatch_cnt_o  out  CNT_W  saturating count of no-match samples
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge clk) has priority over all other activity, including mid-transaction. State=IDLE, gnt_valid_o=0, gnt_id_o=0, gnt_onehot_o=0, multi_o=0, nomatch_o=0, nomatch_cnt_o=0. Any pending grant is discarded.
- States:
  - IDLE: req_ready_o=1, busy_o=0.
  - GRANT: req_ready_o=0, busy_o=1, gnt_valid_o=1.
- Accept: req_valid_i && req_ready_o at a posedge.
- IDLE, accept with |req_i=1:
  - Register the lowest set index into gnt_id_o and gnt_onehot_o.
  - multi_o = (popcount(req_i) > 1).
  - Go to GRANT. gnt_valid_o is high in the next cycle (1-cycle latency).
- IDLE, accept with req_i=0:
  - Stay in IDLE. nomatch_o pulses high for exactly 1 cycle.
  - nomatch_cnt_o increments and saturates at 2^CNT_W-1 (no wrap).
  - Grant outputs keep their previous values; gnt_valid_o stays 0.
- IDLE, no accept: no change. nomatch_o returns to 0.
- GRANT:
  - gnt_id_o, gnt_onehot_o and multi_o are held stable while gnt_valid_o=1 && !gnt_ready_i.
  - req_i and req_valid_i are ignored; upstream must hold its data.
  - When gnt_ready_i=1, return to IDLE. gnt_valid_o=0 next cycle. gnt_id_o, gnt_onehot_o and multi_o hold their last values.
- Throughput: one grant per 2 cycles minimum. There is no same-cycle release-and-accept, because req_ready_o is a registered function of state.
- gnt_ready_i is ignored in IDLE.
- Invariants:
  - gnt_onehot_o == (1 << gnt_id_o) whenever gnt_valid_o=1.
  - gnt_onehot_o has exactly one bit set when gnt_valid_o=1.
- X on req_i during a non-accepted cycle has no effect.

Test Plan:
- Reset release, then req_i=4'b0110 with valid → next cycle gnt_valid_o=1, gnt_id_o=1, gnt_onehot_o=4'b0010, multi_o=1.
- req_i=4'b1000 accepted, gnt_ready_i held 0 for 5 cycles → gnt_id_o=3 stable and req_ready_o=0 throughout. Raise gnt_ready_i → next cycle gnt_valid_o=0, req_ready_o=1.
- req_i=0 with valid, 3 times → three single-cycle nomatch_o pulses, nomatch_cnt_o=3, gnt_valid_o never asserted.
- 260 consecutive no-match samples → nomatch_cnt_o reaches 255 and stays 255.
- While in GRANT, drive req_valid_i=1 with req_i=4'b0001 → ignored. The grant remains at its original id, and no second grant occurs after release unless the sample is re-presented.
- Assert rst_n=0 for 1 cycle while gnt_valid_o=1 and nomatch_cnt_o=7 → all outputs 0 and state IDLE next cycle. A following req_i=4'b0100 yields gnt_id_o=2.
